// File: rtl/register_bank.sv
// rtl/register_bank.sv - register bank with init sweep, busy scoreboard and two combinational read ports
// Optional write-to-read forwarding is enabled by defining REGISTER_BANK_BYPASS_EN.
module register_bank #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ZERO_REGISTER = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     read_enable_a,
    input  logic [ADDRESS_WIDTH-1:0] read_address_a,
    output logic [DATA_WIDTH-1:0]    read_data_a,
    output logic                     read_busy_a,
    input  logic                     read_enable_b,
    input  logic [ADDRESS_WIDTH-1:0] read_address_b,
    output logic [DATA_WIDTH-1:0]    read_data_b,
    output logic                     read_busy_b,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     reserve_enable,
    input  logic [ADDRESS_WIDTH-1:0] reserve_address
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   counter_q, counter_d;
    logic [DATA_WIDTH-1:0]      storage_q [DEPTH];
    logic [DEPTH-1:0]           busy_q;

    logic run, init;
    logic zero_a, zero_b, zero_w, zero_r;
    logic hit_a, hit_b, byp_a, byp_b;

    assign run    = (state_q == ST_RUN) && !reset;
    assign init   = (state_q == ST_INIT) && !reset;
    assign zero_a = (ZERO_REGISTER != 0) && (read_address_a == '0);
    assign zero_b = (ZERO_REGISTER != 0) && (read_address_b == '0);
    assign zero_w = (ZERO_REGISTER != 0) && (write_address == '0);
    assign zero_r = (ZERO_REGISTER != 0) && (reserve_address == '0);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        if (state_q == ST_INIT) begin
            counter_d = counter_q + 1'b1;
            if (counter_q == LAST_INDEX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Storage is deliberately not reset; the sweep clears one entry per cycle.
    always_ff @(posedge clock) begin
        if (init) begin
            storage_q[counter_q] <= '0;
            busy_q[counter_q]    <= 1'b0;
        end else if (run) begin
            if (write_enable && !zero_w) begin
                storage_q[write_address] <= write_data;
            end
            if (write_enable) begin
                busy_q[write_address] <= 1'b0;
            end
            // Issued after the write clear so a new producer on the same register wins.
            if (reserve_enable && !zero_r) begin
                busy_q[reserve_address] <= 1'b1;
            end
        end
    end

    assign hit_a = run && read_enable_a && !zero_a;
    assign hit_b = run && read_enable_b && !zero_b;

`ifdef REGISTER_BANK_BYPASS_EN
    assign byp_a = hit_a && write_enable && (read_address_a == write_address);
    assign byp_b = hit_b && write_enable && (read_address_b == write_address);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign read_data_a = !hit_a ? '0 : (byp_a ? write_data : storage_q[read_address_a]);
    assign read_data_b = !hit_b ? '0 : (byp_b ? write_data : storage_q[read_address_b]);
    assign read_busy_a = hit_a && busy_q[read_address_a] && !byp_a;
    assign read_busy_b = hit_b && busy_q[read_address_b] && !byp_b;
    assign ready       = run;

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bit width of each register.
REQ-002 Parameter ADDRESS_WIDTH, default 5: address bits; DEPTH = 2**ADDRESS_WIDTH registers.
REQ-003 Parameter ZERO_REGISTER, default 1: when 1, address 0 reads as zero, ignores writes and is never busy.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ready  output  1  high once the initialisation sweep is complete.
REQ-007 read_enable_a  input  1  enables read port A.
REQ-008 read_address_a  input  ADDRESS_WIDTH  register address for port A.
REQ-009 read_data_a  output  DATA_WIDTH  combinational read data for port A.
REQ-010 read_busy_a  output  1  port A register has an outstanding reservation.
REQ-011 read_enable_b, read_address_b, read_data_b, read_busy_b SHALL mirror REQ-007..REQ-010 for port B.
REQ-012 write_enable  input  1  write strobe.
REQ-013 write_address  input  ADDRESS_WIDTH  write target.
REQ-014 write_data  input  DATA_WIDTH  write value.
REQ-015 reserve_enable  input  1  marks a register as pending (producer issued).
REQ-016 reserve_address  input  ADDRESS_WIDTH  register to mark pending.

Function
REQ-017 Block SHALL implement a two-state FSM, INIT and RUN, plus a sweep counter of ADDRESS_WIDTH bits.
REQ-018 In INIT, each non-reset cycle SHALL clear storage[counter] and busy[counter], then increment counter; on counter == DEPTH-1 the next state SHALL be RUN.
REQ-019 ready SHALL be 1 exactly when state is RUN; first ready=1 SHALL occur DEPTH rising edges after the first edge with reset low.
REQ-020 In INIT, write_enable and reserve_enable SHALL be ignored; all read_data outputs SHALL be 0 and read_busy outputs SHALL be 0.
REQ-021 Reads SHALL be combinational (zero latency); read_data_x SHALL be 0 when read_enable_x is 0, or when read_address_x is 0 with ZERO_REGISTER=1; otherwise storage[read_address_x] or the bypass value.
REQ-022 In RUN, write_enable=1 SHALL update storage[write_address] at the edge, except address 0 with ZERO_REGISTER=1.
REQ-023 reserve_enable=1 SHALL set busy[reserve_address] at the edge; write_enable=1 SHALL clear busy[write_address] at the edge.
REQ-024 Reserve and write to the same address in the same cycle: data SHALL be written and busy SHALL end at 1 (new producer wins).
REQ-025 read_busy_x SHALL equal read_enable_x AND busy[read_address_x] AND NOT bypass-hit on port x.
REQ-026 Both ports MAY read the same address; each SHALL return identical data and busy.

Reset
REQ-027 reset=1 at an edge SHALL force state INIT and counter 0, including mid-sweep or mid-operation; storage is cleared by the sweep, not by reset.
REQ-028 While reset=1, ready, read_data_a/b and read_busy_a/b SHALL be 0.

Configuration
REQ-029 Macro REGISTER_BANK_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 Defined: in RUN, if write_enable=1, read_enable_x=1, read_address_x == write_address (and not the zero register), read_data_x SHALL equal write_data in that cycle and bypass-hit SHALL be 1.
REQ-031 Undefined: read_data_x SHALL return the pre-edge storage value and bypass-hit SHALL be 0; new data visible the cycle after the write.

Verification
REQ-032 Reset 1 cycle, DATA_WIDTH=32, ADDRESS_WIDTH=5 -> ready=0 for 32 edges, ready=1 on the 32nd edge after reset release; all reads 0 during INIT.
REQ-033 RUN, write 0xDEADBEEF to r7, read r7 next cycle on both ports -> read_data_a=read_data_b=0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-034 RUN, reserve r9, next cycle read r9 -> read_busy_a=1; write r9=0x55 -> with BYPASS_EN same cycle read_data_a=0x55, read_busy_a=0; without, read_data_a=old value, read_busy_a=1, next cycle 0x55 and busy 0.
REQ-035 RUN, reserve r3 and write r3=0xA5 same cycle -> next cycle read_data=0xA5, read_busy=1.
REQ-036 Assert reset at sweep counter 10, release -> ready remains 0 for a full 32 further edges; previously written r7 reads 0 after ready.
